rpn_evaluator: RTL and testbench

- Postfix (RPN) expression evaluator that sits directly upstream of the 8-bit, 32-deep `stack`. It is the stack's only producer of Push/Pop/Data_In and the only consumer of its Data_Out/Full/Empty.
- Tokens arrive over a valid/ready handshake. The result leaves over a second valid/ready handshake.
- Stack underflow, stack overflow, malformed expressions and bad opcodes are reported as sticky error codes.

---
 rtl/rpn_evaluator.sv | 236 +++++++++++++++++++++++
 tb/tb_rpn_evaluator.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_evaluator.sv
// rpn_evaluator
//   Postfix (RPN) expression evaluator driving an external WIDTH-bit, DEPTH-deep
//   stack. Tokens enter over a valid/ready handshake, the final value leaves
//   over a second valid/ready handshake, and faults latch a sticky error code.
//
// Ports
//   Clk, Rst            rising-edge clock, synchronous active-high reset
//   Tok_Valid/Ready     token handshake; Tok_Is_Op selects operator/operand,
//                       Tok_Data carries operand value or opcode in [2:0],
//                       Tok_Last marks the final token of an expression
//   Res_Valid/Ready     result handshake; Result holds the evaluated value
//   Error, Err_Code     sticky flag and code (1 underflow, 2 overflow,
//                       3 leftover operands, 4 bad opcode)
//   Stk_*               connection to the stack (RstN, Push, Pop, Data_In,
//                       Data_Out valid the cycle after a pop, Full, Empty)
module rpn_evaluator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Tok_Valid,
  output logic             Tok_Ready,
  input  logic             Tok_Is_Op,
  input  logic [WIDTH-1:0] Tok_Data,
  input  logic             Tok_Last,
  output logic             Res_Valid,
  input  logic             Res_Ready,
  output logic [WIDTH-1:0] Result,
  output logic             Error,
  output logic [2:0]       Err_Code,
  output logic             Stk_RstN,
  output logic             Stk_Push,
  output logic             Stk_Pop,
  output logic [WIDTH-1:0] Stk_Data_In,
  input  logic [WIDTH-1:0] Stk_Data_Out,
  input  logic             Stk_Full,
  input  logic             Stk_Empty
);

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH, S_POP_B, S_WAIT_B, S_POP_A, S_WAIT_A, S_OPER,
    S_PUSH_R, S_FIN_POP, S_FIN_WAIT, S_FIN_CHK, S_DONE, S_ERROR
  } state_e;

  localparam logic [2:0] ERR_UNDER    = 3'd1;
  localparam logic [2:0] ERR_OVER     = 3'd2;
  localparam logic [2:0] ERR_LEFTOVER = 3'd3;
  localparam logic [2:0] ERR_BADOP    = 3'd4;

  localparam int OccW = $clog2(DEPTH + 1);
  localparam logic [OccW-1:0] OccMax = OccW'(DEPTH);

  state_e           state_q, state_d;
  logic             tok_ready_q, tok_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             error_q, error_d;
  logic [2:0]       err_code_q, err_code_d;
  logic             stk_push_q, stk_push_d;
  logic             stk_pop_q, stk_pop_d;
  logic [WIDTH-1:0] stk_data_in_q, stk_data_in_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [2:0]       op_q, op_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic             raise;
  logic [2:0]       raise_code;

  function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Pop is a registered output, so the stack samples it one cycle after the
  // POP_x decision and its Data_Out lands one cycle after that. B is therefore
  // captured in POP_A, A is consumed directly in OPER and the final value in
  // FIN_CHK. FIN_POP is entered while the final push is still on the bus, so
  // Stk_Empty there is stale and a pending push guarantees a non-empty stack.
  always_comb begin
    state_d       = state_q;
    res_valid_d   = res_valid_q;
    result_d      = result_q;
    error_d       = error_q;
    err_code_d    = err_code_q;
    stk_push_d    = 1'b0;
    stk_pop_d     = 1'b0;
    stk_data_in_d = stk_data_in_q;
    val_d         = val_q;
    op_d          = op_q;
    last_d        = last_q;
    b_d           = b_q;
    r_d           = r_q;
    raise         = 1'b0;
    raise_code    = '0;

    occ_d = occ_q;
    if (stk_push_q)     occ_d = occ_q + OccW'(1);
    else if (stk_pop_q) occ_d = occ_q - OccW'(1);

    case (state_q)
      S_IDLE: begin
        if (Tok_Valid) begin
          val_d  = Tok_Data;
          op_d   = Tok_Data[2:0];
          last_d = Tok_Last;
          if (!Tok_Is_Op)               state_d = S_PUSH;
          else if (Tok_Data[2:0] > 3'd5) begin raise = 1'b1; raise_code = ERR_BADOP; end
          else                          state_d = S_POP_B;
        end
      end
      S_PUSH, S_PUSH_R: begin
        if (Stk_Full) begin
          raise      = 1'b1;
          raise_code = ERR_OVER;
        end else begin
          stk_push_d    = 1'b1;
          stk_data_in_d = (state_q == S_PUSH) ? val_q : r_q;
          state_d       = last_q ? S_FIN_POP : S_IDLE;
        end
      end
      S_POP_B: begin
        if (Stk_Empty) begin raise = 1'b1; raise_code = ERR_UNDER; end
        else begin stk_pop_d = 1'b1; state_d = S_WAIT_B; end
      end
      S_WAIT_B: state_d = S_POP_A;
      S_POP_A: begin
        b_d = Stk_Data_Out;
        if (Stk_Empty) begin raise = 1'b1; raise_code = ERR_UNDER; end
        else begin stk_pop_d = 1'b1; state_d = S_WAIT_A; end
      end
      S_WAIT_A: state_d = S_OPER;
      S_OPER: begin
        r_d     = alu(op_q, Stk_Data_Out, b_q);
        state_d = S_PUSH_R;
      end
      S_FIN_POP: begin
        if (Stk_Empty && !stk_push_q) begin raise = 1'b1; raise_code = ERR_UNDER; end
        else begin stk_pop_d = 1'b1; state_d = S_FIN_WAIT; end
      end
      S_FIN_WAIT: state_d = S_FIN_CHK;
      S_FIN_CHK: begin
        if (!Stk_Empty) begin
          raise      = 1'b1;
          raise_code = ERR_LEFTOVER;
        end else begin
          result_d    = Stk_Data_Out;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (Res_Ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    if (raise) begin
      state_d    = S_ERROR;
      error_d    = 1'b1;
      err_code_d = raise_code;
    end

    tok_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= S_IDLE;
      tok_ready_q   <= 1'b1;
      res_valid_q   <= 1'b0;
      result_q      <= '0;
      error_q       <= 1'b0;
      err_code_q    <= '0;
      stk_push_q    <= 1'b0;
      stk_pop_q     <= 1'b0;
      stk_data_in_q <= '0;
      val_q         <= '0;
      op_q          <= '0;
      last_q        <= 1'b0;
      b_q           <= '0;
      r_q           <= '0;
      occ_q         <= '0;
    end else begin
      state_q       <= state_d;
      tok_ready_q   <= tok_ready_d;
      res_valid_q   <= res_valid_d;
      result_q      <= result_d;
      error_q       <= error_d;
      err_code_q    <= err_code_d;
      stk_push_q    <= stk_push_d;
      stk_pop_q     <= stk_pop_d;
      stk_data_in_q <= stk_data_in_d;
      val_q         <= val_d;
      op_q          <= op_d;
      last_q        <= last_d;
      b_q           <= b_d;
      r_q           <= r_d;
      occ_q         <= occ_d;
    end
  end

  // Shadow occupancy exists only to guard the stack interface.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      assert (!(stk_push_q && stk_pop_q));
      assert (occ_q <= OccMax);
    end
  end

  assign Tok_Ready   = tok_ready_q;
  assign Res_Valid   = res_valid_q;
  assign Result      = result_q;
  assign Error       = error_q;
  assign Err_Code    = err_code_q;
  assign Stk_RstN    = ~Rst;
  assign Stk_Push    = stk_push_q;
  assign Stk_Pop     = stk_pop_q;
  assign Stk_Data_In = stk_data_in_q;

endmodule

// File: tb/tb_rpn_evaluator.sv
// tb_rpn_evaluator
//   Drives rpn_evaluator against a behavioural 8-bit x 32 stack and checks
//   results and error codes against a queue-based postfix reference model.
module tb_rpn_evaluator;
  localparam int WIDTH = 8;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tok_valid = 1'b0, tok_is_op = 1'b0, tok_last = 1'b0;
  logic [WIDTH-1:0] tok_data = '0;
  logic res_ready = 1'b0;
  logic tok_ready, res_valid, error;
  logic [WIDTH-1:0] result;
  logic [2:0] err_code;
  logic stk_rstn, stk_push, stk_pop, stk_full, stk_empty;
  logic [WIDTH-1:0] stk_din, stk_dout;

  logic [WIDTH-1:0] stk_mem [DEPTH];
  logic [5:0] stk_cnt;

  int tests = 0, fails = 0;
  int push_total = 0, pop_total = 0, push_full_viol = 0, both_viol = 0;

  bit q_op[$];
  logic [7:0] q_val[$];

  rpn_evaluator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(clk), .Rst(rst),
    .Tok_Valid(tok_valid), .Tok_Ready(tok_ready), .Tok_Is_Op(tok_is_op),
    .Tok_Data(tok_data), .Tok_Last(tok_last),
    .Res_Valid(res_valid), .Res_Ready(res_ready), .Result(result),
    .Error(error), .Err_Code(err_code),
    .Stk_RstN(stk_rstn), .Stk_Push(stk_push), .Stk_Pop(stk_pop),
    .Stk_Data_In(stk_din), .Stk_Data_Out(stk_dout),
    .Stk_Full(stk_full), .Stk_Empty(stk_empty)
  );

  always #5 clk = ~clk;

  // Stack: Data_Out updates at the edge that samples Pop.
  assign stk_full  = (stk_cnt == 6'(DEPTH));
  assign stk_empty = (stk_cnt == 6'd0);
  always @(posedge clk) begin
    if (!stk_rstn) begin
      stk_cnt  <= '0;
      stk_dout <= '0;
    end else if (stk_push && !stk_full) begin
      stk_mem[stk_cnt[4:0]] <= stk_din;
      stk_cnt <= stk_cnt + 6'd1;
    end else if (stk_pop && !stk_empty) begin
      stk_dout <= stk_mem[5'(stk_cnt - 6'd1)];
      stk_cnt  <= stk_cnt - 6'd1;
    end
  end

  always @(negedge clk) begin
    if (stk_push === 1'b1) push_total <= push_total + 1;
    if (stk_pop === 1'b1) pop_total <= pop_total + 1;
    if (stk_push === 1'b1 && stk_full === 1'b1) push_full_viol <= push_full_viol + 1;
    if (stk_push === 1'b1 && stk_pop === 1'b1) both_viol <= both_viol + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tok_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    check("rst_stk_rstn", stk_rstn, 0);
    check("rst_push", stk_push, 0);
    check("rst_pop", stk_pop, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tok_ready", tok_ready, 1);
    check("post_rst_res_valid", res_valid, 0);
    check("post_rst_error", {error, err_code}, 0);
    check("post_rst_result", result, 0);
    check("post_rst_data_in", stk_din, 0);
    check("post_rst_empty", stk_empty, 1);
    check("post_rst_stk_rstn", stk_rstn, 1);
  endtask

  task automatic send(input bit is_op, input logic [7:0] data, input bit last);
    int n = 0;
    @(negedge clk);
    while (tok_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tok_ready_timeout", (n < 100), 1);
    tok_valid = 1'b1; tok_is_op = is_op; tok_data = data; tok_last = last;
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    tok_data  = 8'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(res_valid === 1'b1 || error === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", (n < 300), 1);
  endtask

  task automatic take_result(input int hold, input logic [7:0] exp);
    res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      check("hold_res_valid", res_valid, 1);
      check("hold_result", result, exp);
      check("hold_tok_ready", tok_ready, 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("res_valid_drop", res_valid, 0);
  endtask

  // Postfix reference: plain stack of ints, errors in token order.
  function automatic void ref_eval(output int err, output logic [7:0] res, output int idx);
    int st[$];
    int a, b, r;
    err = 0; res = '0; idx = q_op.size() - 1;
    for (int i = 0; i < q_op.size(); i++) begin
      if (!q_op[i]) begin
        if (st.size() == DEPTH) begin err = 2; idx = i; break; end
        st.push_back(int'(q_val[i]));
      end else begin
        if (q_val[i][2:0] > 3'd5) begin err = 4; idx = i; break; end
        if (st.size() < 2) begin err = 1; idx = i; break; end
        b = st.pop_back();
        a = st.pop_back();
        case (q_val[i][2:0])
          3'd0: r = a + b;
          3'd1: r = a - b;
          3'd2: r = a * b;
          3'd3: r = a & b;
          3'd4: r = a | b;
          default: r = a ^ b;
        endcase
        st.push_back(r & 255);
      end
    end
    if (err == 0) begin
      if (st.size() != 1) err = 3;
      else res = 8'(st[0]);
    end
  endfunction

  task automatic gen_expr();
    int d = 0, pushed = 0, k, mode;
    q_op.delete(); q_val.delete();
    k = $urandom_range(1, 8);
    mode = $urandom_range(0, 9);
    while (pushed < k || d > 1) begin
      if (pushed < k && (d < 2 || $urandom_range(0, 1) == 1)) begin
        q_op.push_back(1'b0); q_val.push_back(8'($urandom)); d++; pushed++;
      end else begin
        q_op.push_back(1'b1); q_val.push_back({5'($urandom), 3'($urandom_range(0, 5))}); d--;
      end
    end
    case (mode)
      0: begin q_op.push_back(1'b0); q_val.push_back(8'($urandom)); end
      1: begin q_op.push_back(1'b1); q_val.push_back({5'($urandom), 3'($urandom_range(0, 5))}); end
      2: begin q_op.push_back(1'b1); q_val.push_back({5'($urandom), 3'($urandom_range(6, 7))}); end
      default: ;
    endcase
  endtask

  initial begin
    int p0, q0, f0, e_err, e_idx;
    logic [7:0] e_res;

    // Reset
    @(negedge clk);
    check("init_rst_stk_rstn", stk_rstn, 0);
    check("init_rst_push_pop", {stk_push, stk_pop}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("init_tok_ready", tok_ready, 1);
    check("init_res_valid", res_valid, 0);
    check("init_error", {error, err_code}, 0);

    // 3 4 ADD 2 MUL -> 14, with operand/operator push latency
    p0 = push_total; q0 = pop_total;
    send(1'b0, 8'd3, 1'b0);
    @(negedge clk); check("lat_opnd_c1", stk_push, 0);
    @(negedge clk); check("lat_opnd_c2", stk_push, 1); check("lat_opnd_data", stk_din, 3);
    send(1'b0, 8'd4, 1'b0);
    send(1'b1, 8'd0, 1'b0);
    repeat (6) @(negedge clk);
    check("lat_op_c6", stk_push, 0);
    @(negedge clk); check("lat_op_c7", stk_push, 1); check("lat_op_data", stk_din, 7);
    send(1'b0, 8'd2, 1'b0);
    send(1'b1, 8'd2, 1'b1);
    wait_done();
    #1;
    check("mul_result", result, 14);
    check("mul_err", {error, err_code}, 0);
    check("mul_push_cnt", push_total - p0, 5);
    check("mul_pop_cnt", pop_total - q0, 5);
    check("mul_empty", stk_empty, 1);
    take_result(0, 8'd14);

    // 3 5 SUB -> FE ; 20 13 MUL -> 4 with 5-cycle hold
    send(1'b0, 8'd3, 1'b0); send(1'b0, 8'd5, 1'b0); send(1'b1, 8'd1, 1'b1);
    wait_done();
    check("sub_result", result, 8'hFE);
    take_result(1, 8'hFE);
    send(1'b0, 8'd20, 1'b0); send(1'b0, 8'd13, 1'b0); send(1'b1, 8'd2, 1'b1);
    wait_done();
    check("mul_wrap_result", result, 4);
    take_result(5, 8'd4);

    // 5 ADD -> underflow, exactly one pop
    do_reset();
    q0 = pop_total;
    send(1'b0, 8'd5, 1'b0); send(1'b1, 8'd0, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    #1;
    check("uf_code", {error, err_code}, {1'b1, 3'd1});
    check("uf_pops", pop_total - q0, 1);
    check("uf_tok_ready", tok_ready, 0);

    // 1 2(Last) -> leftover
    do_reset();
    q0 = pop_total;
    send(1'b0, 8'd1, 1'b0); send(1'b0, 8'd2, 1'b1);
    wait_done();
    #1;
    check("left_code", {error, err_code}, {1'b1, 3'd3});
    check("left_pops", pop_total - q0, 1);
    check("left_res_valid", res_valid, 0);

    // opcode 7 -> bad opcode, no pop
    do_reset();
    q0 = pop_total;
    send(1'b0, 8'd9, 1'b0); send(1'b1, 8'hFF, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    #1;
    check("badop_code", {error, err_code}, {1'b1, 3'd4});
    check("badop_pops", pop_total - q0, 0);

    // 33 operands -> overflow on the 33rd
    do_reset();
    p0 = push_total; f0 = push_full_viol;
    for (int i = 0; i < DEPTH + 1; i++) send(1'b0, 8'(i + 1), 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    #1;
    check("ovf_code", {error, err_code}, {1'b1, 3'd2});
    check("ovf_pushes", push_total - p0, DEPTH);
    check("ovf_full", stk_full, 1);
    check("ovf_push_while_full", push_full_viol - f0, 0);

    // Reset during WAIT_A of 9 8 ADD
    do_reset();
    send(1'b0, 8'd9, 1'b0); send(1'b0, 8'd8, 1'b0); send(1'b1, 8'd0, 1'b0);
    repeat (4) @(negedge clk);
    check("wait_a_pop", stk_pop, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tok_ready", tok_ready, 1);
    check("mid_rst_outs", {res_valid, error, err_code, stk_push, stk_pop}, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_data_in", stk_din, 0);
    check("mid_rst_empty", stk_empty, 1);
    send(1'b0, 8'd1, 1'b1);
    wait_done();
    check("after_rst_result", result, 1);
    check("after_rst_err", error, 0);
    take_result(0, 8'd1);

    // Randomized expressions against the reference model
    for (int t = 0; t < 40; t++) begin
      gen_expr();
      ref_eval(e_err, e_res, e_idx);
      for (int i = 0; i <= e_idx; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(q_op[i], q_val[i], (i == q_op.size() - 1));
      end
      wait_done();
      check("rnd_error", error, (e_err != 0));
      check("rnd_code", err_code, e_err);
      if (e_err == 0) begin
        check("rnd_result", result, e_res);
        take_result($urandom_range(0, 3), e_res);
        check("rnd_empty", stk_empty, 1);
      end else begin
        do_reset();
      end
    end

    #1;
    check("push_pop_overlap", both_viol, 0);
    check("push_while_full", push_full_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
